// File: rtl/seg7_capture.sv
// Sampling decoder for a multiplexed abcdefg seven-segment bus back to BCD, with a one-entry event holder.
// Optional build macro SEG7_CAPTURE_ALT_GLYPH_EN accepts alternate glyphs for 6, 7 and 9.
module seg7_capture #(
    parameter int unsigned NDIG   = 4,
    parameter int unsigned STABLE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:7]          leds,
    input  logic [NDIG-1:0]     dig_sel,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [1:0]          out_idx,
    output logic [3:0]          out_bcd,
    output logic                out_err,
    output logic [4*NDIG-1:0]   digits,
    output logic                overrun,
    input  logic                ovr_clr
);

    localparam int unsigned SW      = NDIG + 7;
    localparam logic [3:0]  CNT_MAX = 4'(STABLE);
    localparam logic [3:0]  CNT_ARM = 4'(STABLE - 1);

    typedef enum logic {ST_WAIT, ST_HOLD} state_e;

    // Returns {err, bcd}; blank decodes to F without error.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'b1111110: r = {1'b0, 4'd0};
            7'b0110000: r = {1'b0, 4'd1};
            7'b1101101: r = {1'b0, 4'd2};
            7'b1111001: r = {1'b0, 4'd3};
            7'b0110011: r = {1'b0, 4'd4};
            7'b1011011: r = {1'b0, 4'd5};
            7'b1011111: r = {1'b0, 4'd6};
            7'b1110000: r = {1'b0, 4'd7};
            7'b1111111: r = {1'b0, 4'd8};
            7'b1111011: r = {1'b0, 4'd9};
            7'b0000000: r = {1'b0, 4'hF};
`ifdef SEG7_CAPTURE_ALT_GLYPH_EN
            7'b0011111: r = {1'b0, 4'd6};
            7'b1110011: r = {1'b0, 4'd9};
            7'b1110010: r = {1'b0, 4'd7};
`endif
            default:    r = {1'b1, 4'hE};
        endcase
        return r;
    endfunction

    state_e              state_q, state_d;
    logic [SW-1:0]       s_reg_q, s_reg_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic [1:0]          idx_q, idx_d;
    logic [3:0]          bcd_q, bcd_d;
    logic                err_q, err_d;
    logic [4*NDIG-1:0]   digits_q, digits_d;
    logic                ovr_q, ovr_d;

    logic [NDIG-1:0]     sel_c;
    logic                same_c;
    logic                onehot_c;
    logic                capture_c;
    logic                dec_err_c;
    logic [3:0]          dec_bcd_c;
    logic [1:0]          cap_idx_c;
    logic                ovr_set_c;

    assign sel_c = s_reg_q[SW-1:7];

    // Stability tracking, capture decision, shadow registers and output holder.
    always_comb begin
        state_d   = state_q;
        s_reg_d   = {dig_sel, leds};
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        idx_d     = idx_q;
        bcd_d     = bcd_q;
        err_d     = err_q;
        digits_d  = digits_q;
        cap_idx_c = 2'd0;
        ovr_set_c = 1'b0;

        same_c   = (s_reg_d == s_reg_q);
        onehot_c = (sel_c != '0) && ((sel_c & (sel_c - NDIG'(1))) == '0);
        {dec_err_c, dec_bcd_c} = decode(s_reg_q[6:0]);

        if (!same_c)
            cnt_d = 4'd0;
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + 4'd1;

        capture_c = (state_q == ST_WAIT) && same_c && (cnt_q == CNT_ARM) && onehot_c;

        case (state_q)
            ST_WAIT: if (capture_c) state_d = ST_HOLD;
            ST_HOLD: if (!same_c)   state_d = ST_WAIT;
            default:                state_d = ST_WAIT;
        endcase

        if (valid_q && out_ready)
            valid_d = 1'b0;

        if (capture_c) begin
            for (int unsigned i = 0; i < NDIG; i++) begin
                if (sel_c[i]) begin
                    cap_idx_c = 2'(i);
                    digits_d[4*i +: 4] = dec_bcd_c;
                end
            end
            // A held event that is not being accepted wins; the new one is dropped.
            if (!valid_q || out_ready) begin
                valid_d = 1'b1;
                idx_d   = cap_idx_c;
                bcd_d   = dec_bcd_c;
                err_d   = dec_err_c;
            end else begin
                ovr_set_c = 1'b1;
            end
        end

        ovr_d = ovr_set_c | (ovr_q & ~ovr_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_WAIT;
            s_reg_q  <= '0;
            cnt_q    <= 4'd0;
            valid_q  <= 1'b0;
            idx_q    <= 2'd0;
            bcd_q    <= 4'd0;
            err_q    <= 1'b0;
            digits_q <= '1;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_reg_q  <= s_reg_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            bcd_q    <= bcd_d;
            err_q    <= err_d;
            digits_q <= digits_d;
            ovr_q    <= ovr_d;
        end
    end

    assign out_valid = valid_q;
    assign out_idx   = idx_q;
    assign out_bcd   = bcd_q;
    assign out_err   = err_q;
    assign digits    = digits_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed self-checking bench for seg7_capture (NDIG=4, STABLE=4).
module tb_seg7_capture;

    logic        clk;
    logic        rst_n;
    logic [1:7]  leds;
    logic [3:0]  dig_sel;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_idx;
    logic [3:0]  out_bcd;
    logic        out_err;
    logic [15:0] digits;
    logic        overrun;
    logic        ovr_clr;

    int tests;
    int fails;
    int ev_cnt;

    seg7_capture #(.NDIG(4), .STABLE(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .leds      (leds),
        .dig_sel   (dig_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_bcd   (out_bcd),
        .out_err   (out_err),
        .digits    (digits),
        .overrun   (overrun),
        .ovr_clr   (ovr_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs n clock edges, counting handshakes with the inputs as they stand before each edge.
    task automatic cyc(input int n);
        repeat (n) begin
            if (out_valid && out_ready) ev_cnt++;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        tests++;
        if ({out_valid, out_idx, out_bcd, out_err, overrun} !== 9'b0) begin
            fails++;
            $display("FAIL reset_outs got v=%b i=%0d b=%h e=%b o=%b want all 0",
                     out_valid, out_idx, out_bcd, out_err, overrun);
        end
        tests++;
        if (digits !== 16'hFFFF) begin
            fails++;
            $display("FAIL reset_digits got %h want ffff", digits);
        end
    endtask

    task automatic test_basic_capture();
        out_ready = 1'b1;
        dig_sel = 4'b0001; leds = 7'b1111001;
        cyc(5);
        tests++;
        if ({out_valid, out_idx, out_bcd, out_err} !== {1'b1, 2'd0, 4'd3, 1'b0}) begin
            fails++;
            $display("FAIL basic_event got v=%b i=%0d b=%h e=%b want v=1 i=0 b=3 e=0",
                     out_valid, out_idx, out_bcd, out_err);
        end
        tests++;
        if (digits !== 16'hFFF3) begin
            fails++;
            $display("FAIL basic_digits got %h want fff3", digits);
        end
        cyc(4);
        tests++;
        if (out_valid !== 1'b0 || ev_cnt !== 1) begin
            fails++;
            $display("FAIL basic_one_event got v=%b events=%0d want v=0 events=1", out_valid, ev_cnt);
        end
    endtask

    task automatic test_short_pattern();
        dig_sel = 4'b0010; leds = 7'b1101101;
        cyc(4);
        dig_sel = 4'b0000; leds = 7'b0000000;
        cyc(8);
        tests++;
        if (out_valid !== 1'b0 || ev_cnt !== 1 || digits !== 16'hFFF3) begin
            fails++;
            $display("FAIL short_no_capture got v=%b events=%0d digits=%h want v=0 events=1 digits=fff3",
                     out_valid, ev_cnt, digits);
        end
    endtask

    task automatic test_illegal_and_multihot();
        dig_sel = 4'b0100; leds = 7'b0000010;
        cyc(5);
        tests++;
        if ({out_valid, out_idx, out_bcd, out_err} !== {1'b1, 2'd2, 4'hE, 1'b1}) begin
            fails++;
            $display("FAIL illegal_event got v=%b i=%0d b=%h e=%b want v=1 i=2 b=e e=1",
                     out_valid, out_idx, out_bcd, out_err);
        end
        tests++;
        if (digits !== 16'hFEF3) begin
            fails++;
            $display("FAIL illegal_digits got %h want fef3", digits);
        end
        cyc(1);
        dig_sel = 4'b0110; leds = 7'b1111110;
        cyc(8);
        tests++;
        if (out_valid !== 1'b0 || ev_cnt !== 2 || digits !== 16'hFEF3) begin
            fails++;
            $display("FAIL multihot_no_event got v=%b events=%0d digits=%h want v=0 events=2 digits=fef3",
                     out_valid, ev_cnt, digits);
        end
    endtask

    task automatic test_overrun();
        out_ready = 1'b0;
        dig_sel = 4'b0010; leds = 7'b1011011;
        cyc(5);
        tests++;
        if ({out_valid, out_idx, out_bcd, out_err} !== {1'b1, 2'd1, 4'd5, 1'b0} || digits !== 16'hFE53) begin
            fails++;
            $display("FAIL ovr_first got v=%b i=%0d b=%h e=%b d=%h want v=1 i=1 b=5 e=0 d=fe53",
                     out_valid, out_idx, out_bcd, out_err, digits);
        end
        dig_sel = 4'b0100; leds = 7'b1111011;
        cyc(5);
        tests++;
        if ({out_valid, out_idx, out_bcd} !== {1'b1, 2'd1, 4'd5} || overrun !== 1'b1) begin
            fails++;
            $display("FAIL ovr_hold got v=%b i=%0d b=%h ovr=%b want v=1 i=1 b=5 ovr=1",
                     out_valid, out_idx, out_bcd, overrun);
        end
        tests++;
        if (digits !== 16'hF953) begin
            fails++;
            $display("FAIL ovr_digits got %h want f953", digits);
        end
        ovr_clr = 1'b1;
        cyc(1);
        ovr_clr = 1'b0;
        tests++;
        if (overrun !== 1'b0 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL ovr_clear got ovr=%b v=%b want ovr=0 v=1", overrun, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        dig_sel = 4'b1000; leds = 7'b0110000;
        cyc(4);
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
        tests++;
        if ({out_valid, out_idx, out_bcd, out_err} !== {1'b1, 2'd3, 4'd1, 1'b0} || overrun !== 1'b0) begin
            fails++;
            $display("FAIL b2b_event got v=%b i=%0d b=%h e=%b ovr=%b want v=1 i=3 b=1 e=0 ovr=0",
                     out_valid, out_idx, out_bcd, out_err, overrun);
        end
        tests++;
        if (digits !== 16'h1953 || ev_cnt !== 3) begin
            fails++;
            $display("FAIL b2b_digits got d=%h events=%0d want d=1953 events=3", digits, ev_cnt);
        end
        dig_sel = 4'b0001; leds = 7'b1111111;
        cyc(2);
        rst_n = 1'b0;
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_alt_glyph();
        out_ready = 1'b1;
        dig_sel = 4'b0001; leds = 7'b0011111;
        cyc(5);
        tests++;
`ifdef SEG7_CAPTURE_ALT_GLYPH_EN
        if ({out_valid, out_bcd, out_err} !== {1'b1, 4'd6, 1'b0}) begin
            fails++;
            $display("FAIL alt_glyph got v=%b b=%h e=%b want v=1 b=6 e=0", out_valid, out_bcd, out_err);
        end
`else
        if ({out_valid, out_bcd, out_err} !== {1'b1, 4'hE, 1'b1}) begin
            fails++;
            $display("FAIL alt_glyph got v=%b b=%h e=%b want v=1 b=e e=1", out_valid, out_bcd, out_err);
        end
`endif
        dig_sel = 4'b0010; leds = 7'b0000000;
        cyc(5);
        tests++;
        if ({out_valid, out_idx, out_bcd, out_err} !== {1'b1, 2'd1, 4'hF, 1'b0}) begin
            fails++;
            $display("FAIL blank_event got v=%b i=%0d b=%h e=%b want v=1 i=1 b=f e=0",
                     out_valid, out_idx, out_bcd, out_err);
        end
    endtask

    initial begin
        tests = 0; fails = 0; ev_cnt = 0;
        rst_n = 1'b0; leds = 7'b0; dig_sel = 4'b0; out_ready = 1'b0; ovr_clr = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_basic_capture();
        test_short_pattern();
        test_illegal_and_multihot();
        test_overrun();
        test_back_to_back();
        test_alt_glyph();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg7_capture.md
# seg7_capture

Sampling decoder for a multiplexed, active-high abcdefg seven-segment bus: the inverse of the team's BCD-to-segment encoder. It watches the segment lines and one-hot digit strobes, waits for each pattern to be stable, and decodes it back to BCD. Each capture updates a per-digit shadow register and is offered as a valid/ready event. The block sits on the display side for loopback self-check and for scraping external panel drivers.

## Interface
Parameters:
- `NDIG`, default 4: number of multiplexed digits; legal range 1..4.
- `STABLE`, default 4: consecutive matching samples required before capture; legal range 2..15.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `leds` in [1:7]: segments a..g, bit 1 = a; 1 = lit.
- `dig_sel` in [NDIG-1:0]: one-hot digit strobe.
- `out_valid` out 1: a capture event is held.
- `out_ready` in 1: the consumer accepts the event.
- `out_idx` out 2: digit index of the held event.
- `out_bcd` out 4: decoded value of the held event.
- `out_err` out 1: the held event was an illegal pattern.
- `digits` out [4*NDIG-1:0]: last decoded value per digit; digit i is at [4i+3:4i].
- `overrun` out 1: sticky flag; an event was dropped.
- `ovr_clr` in 1: synchronous clear of `overrun`.

## Operation
Decode rule, from `leds` (abcdefg) to BCD:
- 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4, 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9.
- Blank (0000000) → 4'hF with err=0.
- Any other pattern → 4'hE with err=1.

Input stage:
- Register `s_reg` holds {dig_sel, leds} and is sampled every edge.
- A 4-bit counter `cnt` tracks stability. When the incoming sample differs from `s_reg`, `cnt` is set to 0. Otherwise `cnt` increments and saturates at STABLE.

FSM states:
- WAIT (the reset state):
  - Moves to HOLD on the edge where `cnt` goes from STABLE-1 to STABLE and `s_reg` sel is exactly one-hot. This edge is the capture edge.
  - If sel is zero or multi-hot, it stays in WAIT and no event is produced.
- HOLD:
  - Returns to WAIT on any sample change.
  - This state guarantees one event per stable pattern.

Capture edge:
- `digits[idx]` is updated with the decoded value, where idx is the position of the set sel bit.
- The event {idx, bcd, err} is offered to the one-entry output holder.

Output holder:
- A transfer occurs on an edge with out_valid && out_ready.
- Capture and transfer on the same edge: the new event is loaded and out_valid stays 1.
- Capture while out_valid && !out_ready: the new event is dropped, the holder is unchanged, `overrun` is set to 1, and `digits` is still updated.
- `ovr_clr` clears `overrun`. If a set condition occurs on the same edge, set wins.

Reset:
- Reset values: out_valid=0, out_idx=0, out_bcd=0, out_err=0, overrun=0, every digits nibble=4'hF, s_reg=0, cnt=0, FSM=WAIT.
- Reset asserted mid-operation aborts immediately and drops any held event.

## Timing
- Let edge 0 be the first edge that samples a new pattern P, stable thereafter.
- Edges 1..STABLE increment `cnt`.
- Edge STABLE is the capture edge: out_valid and `digits` reflect P from edge STABLE onward. With STABLE=4, that is 5 edges after P first appears.
- A pattern held fewer than STABLE+1 consecutive samples is never captured.
- out_valid deasserts on the edge after acceptance, unless a same-edge capture occurs.
- All outputs are registered; there is no combinational path from input to output. `out_ready` affects state only at the clock edge.

## Configuration
- Macro: `SEG7_CAPTURE_ALT_GLYPH_EN`.
- Defined: alternate glyphs are also accepted as legal digits with err=0: 0011111→6, 1110011→9, 1110010→7.
- Undefined: these three patterns decode as illegal (4'hE, err=1).
- Nothing else changes between the two builds.

## Test plan
- Reset release, then dig_sel=0001 and leds=1111001 held 6 cycles, out_ready=1 → after the 5th edge: out_valid=1, out_idx=0, out_bcd=3, out_err=0, digits[3:0]=3; exactly one event.
- Pattern held only 4 samples, then changed → no event, digits unchanged (4'hF).
- dig_sel=0100 and leds=0000010 held → event idx=2, bcd=4'hE, err=1. dig_sel=0110 held → no event.
- out_ready=0, then two successive stable captures: digit1=5 followed by digit2=9 → holder keeps idx=1/bcd=5, overrun=1, digits[11:8]=9. Then pulse ovr_clr with no capture → overrun=0.
- Capture coincident with acceptance (out_valid=1, out_ready=1 on the capture edge) → out_valid stays 1 and the holder carries the new event. Then rst_n low mid-count → all outputs return to their reset values asynchronously.
- With `SEG7_CAPTURE_ALT_GLYPH_EN` defined, leds=0011111 → bcd=6, err=0. Undefined: bcd=4'hE, err=1.
